pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage core (F, D, E, M, W). It combines the decode-stage load-use hazard, the decode-stage PC prediction, execute-stage mispredict correction, multi-cycle execute ops (DIV/FPU) and data-memory wait into per-stage stall/flush controls. It owns the multi-cycle busy FSM with timeout and defers flushes that arrive during a memory freeze.

---
 rtl/pipeline_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
//-----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage core (F, D, E, M, W).
// Merges the decode load-use hazard, decode PC prediction, execute
// mispredict correction, multi-cycle execute ops (DIV/FPU) and data-memory
// wait into per-stage stall/flush controls. Owns the multi-cycle busy FSM
// (with timeout) and remembers a mispredict that arrives while memory
// freezes the pipe, replaying the flush once the freeze lifts.
//
// Parameters:
//   MC_TIMEOUT   max cycles spent in MC_BUSY before forced release (>=2)
//   MC_CNT_BITS  width of the multi-cycle counter (must hold MC_TIMEOUT)
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   When defined, adds perfStallCycles_o / perfFlushCount_o counters.
//
// Ports:
//   clk_i              clock, all state updates on rising edge
//   reset_i            synchronous, active-high reset
//   D_dataHazard_i     load-use / load-after-store hazard from decode
//   D_predictPC_i      decode wants fetch redirected to its predicted PC
//   E_correctPC_i      execute detected mispredict
//   E_mcStart_i        multi-cycle op present in E this cycle
//   E_mcDone_i         multi-cycle unit result valid this cycle
//   M_memBusy_i        data memory not ready; M must hold
//   F_stall_o          hold PC/fetch register
//   F_takePred_o       fetch loads decode's predicted PC
//   D_stall_o          hold FD/DE registers
//   D_flush_o          invalidate FD register
//   E_stall_o          hold E stage
//   E_flush_o          insert bubble into DE
//   M_bubble_o         EM register loads bubble
//   M_stall_o          hold M stage
//   perfStallCycles_o  (PIPE_CTRL_PERF_EN) cycles with any stage stalled
//   perfFlushCount_o   (PIPE_CTRL_PERF_EN) mispredict flushes issued
//   mcTimeout_o        registered one-cycle pulse on multi-cycle timeout
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module pipeline_hazard_ctrl #(
   parameter int MC_TIMEOUT  = 64,
   parameter int MC_CNT_BITS = 7
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        D_dataHazard_i,
   input  logic        D_predictPC_i,
   input  logic        E_correctPC_i,
   input  logic        E_mcStart_i,
   input  logic        E_mcDone_i,
   input  logic        M_memBusy_i,
   output logic        F_stall_o,
   output logic        F_takePred_o,
   output logic        D_stall_o,
   output logic        D_flush_o,
   output logic        E_stall_o,
   output logic        E_flush_o,
   output logic        M_bubble_o,
   output logic        M_stall_o,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0] perfStallCycles_o,
   output logic [31:0] perfFlushCount_o,
`endif
   output logic        mcTimeout_o
);

   typedef enum logic {
      RUN     = 1'b0,
      MC_BUSY = 1'b1
   } fsm_t;

   localparam logic [MC_CNT_BITS-1:0] CNT_LAST = MC_CNT_BITS'(MC_TIMEOUT - 1);
   localparam logic [MC_CNT_BITS-1:0] CNT_ONE  = MC_CNT_BITS'(1);

   fsm_t                   fsm;
   fsm_t                   fsm_nxt;
   logic [MC_CNT_BITS-1:0] mc_cnt;
   logic [MC_CNT_BITS-1:0] mc_cnt_nxt;
   logic                   pend_flush;
   logic                   pend_flush_nxt;
   logic                   timeout_nxt;

   logic                   correct_eff;
   logic                   mc_stall;
   logic                   flush_sel;

   // While a multi-cycle op holds E, no other instruction can reach E, so
   // a correction seen in MC_BUSY is spurious and dropped.
   assign correct_eff = E_correctPC_i && (fsm == RUN);

   // Stall while the op is outstanding; a start that completes in the same
   // cycle never stalls.
   assign mc_stall = ((fsm == MC_BUSY) && !E_mcDone_i) ||
                     ((fsm == RUN) && E_mcStart_i && !E_mcDone_i);

   // Mispredict flush wins only when neither memory nor the MC unit holds
   // the pipe; a deferred flush is replayed here as well.
   assign flush_sel = !reset_i && !M_memBusy_i && !mc_stall &&
                      (correct_eff || pend_flush);

   //--------------------------------------------------------------------------
   // State register
   //--------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         fsm         <= RUN;
         mc_cnt      <= '0;
         pend_flush  <= 1'b0;
         mcTimeout_o <= 1'b0;
      end else begin
         fsm         <= fsm_nxt;
         mc_cnt      <= mc_cnt_nxt;
         pend_flush  <= pend_flush_nxt;
         mcTimeout_o <= timeout_nxt;
      end
   end

   //--------------------------------------------------------------------------
   // Next-state logic
   //--------------------------------------------------------------------------
   always_comb begin
      fsm_nxt     = fsm;
      mc_cnt_nxt  = mc_cnt;
      timeout_nxt = 1'b0;

      // A memory freeze holds the FSM and counter exactly where they are.
      if (!M_memBusy_i) begin
         unique case (fsm)
            RUN: begin
               if (E_mcStart_i && !E_mcDone_i) begin
                  fsm_nxt    = MC_BUSY;
                  mc_cnt_nxt = '0;
               end
            end
            MC_BUSY: begin
               if (E_mcDone_i) begin
                  fsm_nxt = RUN;
               end else if (mc_cnt == CNT_LAST) begin
                  fsm_nxt     = RUN;
                  timeout_nxt = 1'b1;
               end else begin
                  mc_cnt_nxt = mc_cnt + CNT_ONE;
               end
            end
            default: fsm_nxt = RUN;
         endcase
      end

      pend_flush_nxt = pend_flush;
      if (M_memBusy_i) begin
         pend_flush_nxt = pend_flush || correct_eff;
      end else if (flush_sel) begin
         pend_flush_nxt = 1'b0;
      end
   end

   //--------------------------------------------------------------------------
   // Output logic
   //--------------------------------------------------------------------------
   always_comb begin
      F_stall_o    = 1'b0;
      F_takePred_o = 1'b0;
      D_stall_o    = 1'b0;
      D_flush_o    = 1'b0;
      E_stall_o    = 1'b0;
      E_flush_o    = 1'b0;
      M_bubble_o   = 1'b0;
      M_stall_o    = 1'b0;

      if (reset_i) begin
         // Keep the pipe empty while reset is held.
         D_flush_o  = 1'b1;
         E_flush_o  = 1'b1;
         M_bubble_o = 1'b1;
      end else if (M_memBusy_i) begin
         F_stall_o = 1'b1;
         D_stall_o = 1'b1;
         E_stall_o = 1'b1;
         M_stall_o = 1'b1;
      end else if (mc_stall) begin
         // M drains its current instruction and takes bubbles behind it.
         F_stall_o  = 1'b1;
         D_stall_o  = 1'b1;
         E_stall_o  = 1'b1;
         M_bubble_o = 1'b1;
      end else if (flush_sel) begin
         // Hazard and prediction belong to the squashed instructions.
         D_flush_o = 1'b1;
         E_flush_o = 1'b1;
      end else if (D_dataHazard_i) begin
         F_stall_o = 1'b1;
         D_stall_o = 1'b1;
         E_flush_o = 1'b1;
      end else if (D_predictPC_i) begin
         F_takePred_o = 1'b1;
         D_flush_o    = 1'b1;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic any_stall;

   assign any_stall = F_stall_o || D_stall_o || E_stall_o || M_stall_o;

   // Counters wrap naturally modulo 2^32.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         perfStallCycles_o <= '0;
         perfFlushCount_o  <= '0;
      end else begin
         if (any_stall) begin
            perfStallCycles_o <= perfStallCycles_o + 32'd1;
         end
         if (flush_sel) begin
            perfFlushCount_o <= perfFlushCount_o + 32'd1;
         end
      end
   end
`endif

endmodule
